clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Purpose: clock-gate enable controller with a round-robin grant for NUM_REQ requesters.
// Latency: first grant WAKE_CYC+1 edges after a request from IDLE; a grant handover takes 1 edge; CLK_EN drops IDLE_CYC+1 edges after the last release.
// Backpressure: a requester holds REQ high until it is granted; GNT stays with it until its REQ falls, with no preemption.
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 2,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               TEST_EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               CLK_EN,
  output logic               BUSY
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAKE  = 2'd1,
    S_GRANT = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic               clk_en_q;
  logic [IW-1:0]      last;

  logic               rr_found;
  logic [IW-1:0]      rr_idx;
  logic [NUM_REQ-1:0] rr_onehot;
  logic               own_req;

  // Round-robin pick: the requester closest after LAST (wrapping) wins.
  always_comb begin
    int d;
    int best_d;
    rr_found = 1'b0;
    rr_idx   = '0;
    d        = 0;
    best_d   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
      if (REQ[i] && (d < best_d)) begin
        best_d   = d;
        rr_found = 1'b1;
        rr_idx   = IW'(i);
      end
    end
    rr_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_idx;
  end

  // Current owner still holding its request.
  assign own_req = |(REQ & gnt_q);

  // Control FSM: state, wake/cool counter, grant, clock enable and round-robin pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gnt_q    <= '0;
      clk_en_q <= 1'b0;
      last     <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          gnt_q <= '0;
          if (|REQ) begin
            state    <= S_WAKE;
            cnt      <= 4'(WAKE_CYC - 1);
            clk_en_q <= 1'b1;
          end else begin
            clk_en_q <= TEST_EN;
          end
        end
        S_WAKE: begin
          clk_en_q <= 1'b1;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (rr_found) begin
            state <= S_GRANT;
            gnt_q <= rr_onehot;
            last  <= rr_idx;
          end else begin
            state <= S_COOL;
            cnt   <= 4'(IDLE_CYC - 1);
          end
        end
        S_GRANT: begin
          clk_en_q <= 1'b1;
          if (!own_req) begin
            if (rr_found) begin
              // Hand straight over to the next pending requester, no gap cycle.
              gnt_q <= rr_onehot;
              last  <= rr_idx;
            end else begin
              gnt_q <= '0;
              state <= S_COOL;
              cnt   <= 4'(IDLE_CYC - 1);
            end
          end
        end
        S_COOL: begin
          if (rr_found) begin
            // Clock is still running, so regrant without a wake delay.
            state    <= S_GRANT;
            gnt_q    <= rr_onehot;
            last     <= rr_idx;
            clk_en_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state    <= S_IDLE;
            clk_en_q <= TEST_EN;
          end else begin
            cnt      <= cnt - 4'd1;
            clk_en_q <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          gnt_q    <= '0;
          clk_en_q <= TEST_EN;
        end
      endcase
    end
  end

  assign GNT    = gnt_q;
  assign CLK_EN = clk_en_q;
  assign BUSY   = (state != S_IDLE);

endmodule
